pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage core pipeline.
- Decides each cycle whether the PC and the IF/ID, ID/EX and EX/MEM registers load, hold or bubble.
- Inputs: load-use hazards, control-flow redirects (JAL resolved in ID; branch/JALR resolved in EX) and instruction/data memory wait handshakes.
- Owns multi-cycle sequencing: redirect shadow flush, load-use latency and memory waits.

Parameters:
- CORE, 0, core index (per-core instantiation tag, no functional effect).
- REG_BITS, 5, register index width.
- LOAD_USE_CYCLES, 1, bubbles inserted per load-use hazard (1..7).
- REDIRECT_CYCLES, 2, IF/ID flush cycles after a redirect (covers registered IF target path; 1..3).

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- id_rs1  in  REG_BITS  ID source register 1.
- id_rs2  in  REG_BITS  ID source register 2.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  REG_BITS  EX destination register.
- ex_mem_read  in  1  EX instruction is a load.
- cu_next_PC_select  in  2  ID next-PC select: 00 PC+4, 01 branch, 10 JAL, 11 JALR.
- ex_branch  in  1  branch taken, resolved in EX.
- ex_jalr  in  1  JALR executing in EX.
- imem_ready  in  1  instruction memory data valid this cycle.
- mem_access  in  1  MEM stage holds a load/store.
- dmem_ready  in  1  data memory completes this cycle.
- pc_stall  out  1  PC holds.
- if_id_stall  out  1  IF/ID holds.
- if_id_flush  out  1  IF/ID loads a NOP.
- id_ex_stall  out  1  ID/EX holds.
- id_ex_bubble  out  1  ID/EX loads a NOP.
- ex_mem_stall  out  1  EX/MEM holds.
- ctrl_state  out  3  current FSM state, for debug.

Behaviour:
- Outputs are combinational (Mealy) from the registered state/counter and current inputs. State and counter update on posedge clock.
- While reset is low:
  - State is RUN; counters are 0.
  - if_id_flush=1 and id_ex_bubble=1; all stall outputs are 0.
- Derived requests:
  - lu_hit = ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
  - ex_redir = ex_branch | ex_jalr.
  - id_redir = (cu_next_PC_select==2'b10).
  - dwait = mem_access & ~dmem_ready.
- Priority, highest first: dwait > ex_redir > id_redir > lu_hit / LOAD_USE > imem wait.
- States are RUN, LOAD_USE, REDIRECT and DMEM_WAIT.
- dwait, in any state:
  - pc_stall, if_id_stall, id_ex_stall and ex_mem_stall are all 1; no flush or bubble.
  - State moves to DMEM_WAIT; the prior state and counter are frozen and resume unchanged when dwait clears.
- ex_redir:
  - if_id_flush=1 and id_ex_bubble=1; pc_stall=0 so the PC loads the target.
  - Counter is loaded with REDIRECT_CYCLES-1; go to REDIRECT if that is >0, else RUN.
  - A pending LOAD_USE is abandoned.
- id_redir (no ex_redir): if_id_flush=1 for 1 cycle only; ID/EX is not bubbled.
- REDIRECT:
  - if_id_flush=1 each cycle; counter decrements; return to RUN at 0.
  - A new ex_redir reloads the counter.
- lu_hit in RUN: pc_stall=1, if_id_stall=1, id_ex_bubble=1.
  - If LOAD_USE_CYCLES>1, load counter=LOAD_USE_CYCLES-1 and go to LOAD_USE.
  - LOAD_USE repeats the same outputs, decrements the counter and returns to RUN at 0.
- Imem wait (~imem_ready, no higher event): pc_stall=1 and if_id_flush=1; later stages advance.
  - A redirect in the same cycle overrides pc_stall to 0.
- When if_id_stall and if_id_flush are both candidates, flush wins and stall is driven 0.
- ctrl_state encoding: RUN=0, LOAD_USE=1, REDIRECT=2, DMEM_WAIT=3.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- Defined: add outputs perf_stall_cycles[31:0] and perf_flush_cycles[31:0], both reset to 0.
  - perf_stall_cycles increments on any cycle with pc_stall=1.
  - perf_flush_cycles increments on any cycle with if_id_flush=1, except while reset is low.
  - Both counters wrap at 2^32.
- Undefined: ports exist and are tied to 0; no counter flops.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - state enum and encodings;
  - next_PC_select encodings (NPC_PLUS4, NPC_BRANCH, NPC_JAL, NPC_JALR);
  - REG_BITS default and NOP encoding constant.
- Sub-module hazard_detect: combinational lu_hit comparator, reusable by a future forwarding unit.

Test Plan:
- Load x5 in EX, ID add x6,x5,x1 -> 1 cycle of pc_stall=if_id_stall=id_ex_bubble=1, then RUN. With ex_rd=0, no stall.
- ex_branch=1 with REDIRECT_CYCLES=2 -> cycle 0: if_id_flush and id_ex_bubble; cycle 1: if_id_flush only, ctrl_state=2; cycle 2: RUN.
- cu_next_PC_select=2'b10 -> exactly 1 if_id_flush cycle; id_ex_bubble=0.
- mem_access=1, dmem_ready=0 for 3 cycles during REDIRECT count 1 -> all four stalls high for 3 cycles, then 1 more flush cycle, then RUN.
- lu_hit and ex_jalr in the same cycle -> flush/bubble only, no pc_stall, no LOAD_USE entry.
- reset dropped low mid-LOAD_USE -> immediately ctrl_state=0, stalls 0, if_id_flush=1. After reset release, normal RUN; perf counters (if enabled) read 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer and its neighbours.
package pipeline_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_LOAD_USE  = 3'd1,
    ST_REDIRECT  = 3'd2,
    ST_DMEM_WAIT = 3'd3
  } ctrl_state_e;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JAL    = 2'b10;
  localparam logic [1:0] NPC_JALR   = 2'b11;

  localparam int REG_BITS_DEF = 5;
  // addi x0,x0,0 -- what IF/ID and ID/EX load when flushed or bubbled
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int CNT_W = 3;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle: pipeline status in, stage load/hold/bubble commands out.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_BITS = pipeline_ctrl_pkg::REG_BITS_DEF
);
  logic [REG_BITS-1:0] id_rs1;
  logic [REG_BITS-1:0] id_rs2;
  logic                id_uses_rs1;
  logic                id_uses_rs2;
  logic [REG_BITS-1:0] ex_rd;
  logic                ex_mem_read;
  logic [1:0]          cu_next_PC_select;
  logic                ex_branch;
  logic                ex_jalr;
  logic                imem_ready;
  logic                mem_access;
  logic                dmem_ready;

  logic                pc_stall;
  logic                if_id_stall;
  logic                if_id_flush;
  logic                id_ex_stall;
  logic                id_ex_bubble;
  logic                ex_mem_stall;
  logic [2:0]          ctrl_state;
  logic [31:0]         perf_stall_cycles;
  logic [31:0]         perf_flush_cycles;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           cu_next_PC_select, ex_branch, ex_jalr, imem_ready, mem_access, dmem_ready,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_stall,
           ctrl_state, perf_stall_cycles, perf_flush_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           cu_next_PC_select, ex_branch, ex_jalr, imem_ready, mem_access, dmem_ready,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_stall,
           ctrl_state, perf_stall_cycles, perf_flush_cycles
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a load in EX writes.
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_BITS = REG_BITS_DEF
) (
  input  logic [REG_BITS-1:0] id_rs1_i,
  input  logic [REG_BITS-1:0] id_rs2_i,
  input  logic                id_uses_rs1_i,
  input  logic                id_uses_rs2_i,
  input  logic [REG_BITS-1:0] ex_rd_i,
  input  logic                ex_mem_read_i,
  output logic                lu_hit_o
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
  assign rs2_match = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
  // x0 is never a real dependency
  assign lu_hit_o  = ex_mem_read_i && (ex_rd_i != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Optional perf counters are
// built when PIPE_HAZARD_PERF_EN is defined; otherwise the perf ports read 0.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CORE            = 0,
  parameter int REG_BITS        = REG_BITS_DEF,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int REDIRECT_CYCLES = 2
) (
  input logic                  clock,
  input logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LU_RELOAD = CNT_W'(LOAD_USE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_RELOAD = CNT_W'(REDIRECT_CYCLES - 1);
  localparam int               CORE_ID   = CORE;

  logic unused_core;
  assign unused_core = CORE_ID[0];

  ctrl_state_e      state_q, state_d;
  ctrl_state_e      prev_q, prev_d;
  ctrl_state_e      eff_state;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic lu_hit, ex_redir, id_redir, dwait;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_stall;
  logic pc_stall_o, if_id_flush_o;

  hazard_detect #(.REG_BITS(REG_BITS)) u_hd (
    .id_rs1_i      (bus.id_rs1),
    .id_rs2_i      (bus.id_rs2),
    .id_uses_rs1_i (bus.id_uses_rs1),
    .id_uses_rs2_i (bus.id_uses_rs2),
    .ex_rd_i       (bus.ex_rd),
    .ex_mem_read_i (bus.ex_mem_read),
    .lu_hit_o      (lu_hit)
  );

  assign ex_redir = bus.ex_branch | bus.ex_jalr;
  assign id_redir = (bus.cu_next_PC_select == NPC_JAL);
  assign dwait    = bus.mem_access & ~bus.dmem_ready;

  always_comb begin
    // DMEM_WAIT is transparent: decisions resume from the state it froze
    eff_state    = (state_q == ST_DMEM_WAIT) ? prev_q : state_q;
    state_d      = eff_state;
    prev_d       = prev_q;
    cnt_d        = cnt_q;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_stall = 1'b0;

    if (dwait) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      state_d      = ST_DMEM_WAIT;
      prev_d       = eff_state;
    end else if (ex_redir) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      cnt_d        = RD_RELOAD;
      state_d      = (RD_RELOAD != '0) ? ST_REDIRECT : ST_RUN;
    end else if (id_redir) begin
      if_id_flush = 1'b1;
      if (eff_state == ST_REDIRECT) begin
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q <= 1) ? ST_RUN : ST_REDIRECT;
      end else begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
    end else if (eff_state == ST_REDIRECT) begin
      if_id_flush = 1'b1;
      pc_stall    = ~bus.imem_ready;
      cnt_d       = cnt_q - 1'b1;
      state_d     = (cnt_q <= 1) ? ST_RUN : ST_REDIRECT;
    end else if (eff_state == ST_LOAD_USE || lu_hit) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_bubble = 1'b1;
      if (eff_state == ST_LOAD_USE) begin
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q <= 1) ? ST_RUN : ST_LOAD_USE;
      end else begin
        cnt_d   = LU_RELOAD;
        state_d = (LU_RELOAD != '0) ? ST_LOAD_USE : ST_RUN;
      end
    end else if (!bus.imem_ready) begin
      pc_stall    = 1'b1;
      if_id_flush = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      prev_q  <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset forces NOPs into IF/ID and ID/EX and releases every hold
  assign pc_stall_o        = reset & pc_stall;
  assign if_id_flush_o     = ~reset | if_id_flush;
  assign bus.pc_stall      = pc_stall_o;
  assign bus.if_id_flush   = if_id_flush_o;
  assign bus.if_id_stall   = reset & if_id_stall & ~if_id_flush;
  assign bus.id_ex_stall   = reset & id_ex_stall;
  assign bus.id_ex_bubble  = ~reset | id_ex_bubble;
  assign bus.ex_mem_stall  = reset & ex_mem_stall;
  assign bus.ctrl_state    = state_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (pc_stall_o)    perf_stall_q <= perf_stall_q + 32'd1;
      if (if_id_flush_o) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign bus.perf_stall_cycles = perf_stall_q;
  assign bus.perf_flush_cycles = perf_flush_q;
`else
  assign bus.perf_stall_cycles = '0;
  assign bus.perf_flush_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (1- and 3-cycle load-use) against a count-based model.
module tb_pipeline_hazard_ctrl;

  localparam int RC = 2;
  localparam int LUC_A = 1;
  localparam int LUC_B = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  pipeline_hazard_ctrl_if #(.REG_BITS(5)) ifa ();
  pipeline_hazard_ctrl_if #(.REG_BITS(5)) ifb ();

  pipeline_hazard_ctrl #(.CORE(0), .REG_BITS(5), .LOAD_USE_CYCLES(LUC_A), .REDIRECT_CYCLES(RC))
    dut_a (.clock(clock), .reset(reset), .bus(ifa));
  pipeline_hazard_ctrl #(.CORE(1), .REG_BITS(5), .LOAD_USE_CYCLES(LUC_B), .REDIRECT_CYCLES(RC))
    dut_b (.clock(clock), .reset(reset), .bus(ifb));

  int total = 0;
  int bad   = 0;

  // stimulus
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, mr, br, jr, imr, ma, dr;
  logic [1:0] npc;

  // model: remaining extra cycles of each multi-cycle activity
  int          m_lu  [2];
  int          m_rd  [2];
  bit          m_frz [2];
  logic [31:0] m_ps  [2];
  logic [31:0] m_pf  [2];
  int          luc   [2] = '{LUC_A, LUC_B};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive();
    ifa.id_rs1 = rs1; ifa.id_rs2 = rs2; ifa.id_uses_rs1 = u1; ifa.id_uses_rs2 = u2;
    ifa.ex_rd = rd; ifa.ex_mem_read = mr; ifa.cu_next_PC_select = npc;
    ifa.ex_branch = br; ifa.ex_jalr = jr; ifa.imem_ready = imr;
    ifa.mem_access = ma; ifa.dmem_ready = dr;
    ifb.id_rs1 = rs1; ifb.id_rs2 = rs2; ifb.id_uses_rs1 = u1; ifb.id_uses_rs2 = u2;
    ifb.ex_rd = rd; ifb.ex_mem_read = mr; ifb.cu_next_PC_select = npc;
    ifb.ex_branch = br; ifb.ex_jalr = jr; ifb.imem_ready = imr;
    ifb.mem_access = ma; ifb.dmem_ready = dr;
  endtask

  task automatic idle();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; u1 = 0; u2 = 0; mr = 0; npc = 2'b00;
    br = 0; jr = 0; imr = 1; ma = 0; dr = 1;
  endtask

  task automatic get_obs(input int k, output logic [5:0] o, output logic [2:0] st,
                         output logic [31:0] ps, output logic [31:0] pf);
    if (k == 0) begin
      o  = {ifa.pc_stall, ifa.if_id_stall, ifa.if_id_flush, ifa.id_ex_stall, ifa.id_ex_bubble, ifa.ex_mem_stall};
      st = ifa.ctrl_state; ps = ifa.perf_stall_cycles; pf = ifa.perf_flush_cycles;
    end else begin
      o  = {ifb.pc_stall, ifb.if_id_stall, ifb.if_id_flush, ifb.id_ex_stall, ifb.id_ex_bubble, ifb.ex_mem_stall};
      st = ifb.ctrl_state; ps = ifb.perf_stall_cycles; pf = ifb.perf_flush_cycles;
    end
  endtask

  task automatic check_perf(input string tag, input int k, input logic [31:0] ps, input logic [31:0] pf);
`ifdef PIPE_HAZARD_PERF_EN
    chk($sformatf("%s/%0d.perf_stall", tag, k), ps, m_ps[k]);
    chk($sformatf("%s/%0d.perf_flush", tag, k), pf, m_pf[k]);
`else
    chk($sformatf("%s/%0d.perf_stall", tag, k), ps, 32'd0);
    chk($sformatf("%s/%0d.perf_flush", tag, k), pf, 32'd0);
`endif
  endtask

  // Called at posedge+1: apply inputs, check outputs against model, advance one cycle.
  task automatic step(input string tag);
    logic [5:0] o; logic [2:0] st; logic [31:0] ps, pf;
    bit lu, exr, idr, dw;
    bit e_pc, e_ifs, e_iff, e_ids, e_idb, e_exs;
    int e_st;
    drive();
    #2;
    lu  = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    exr = br | jr;
    idr = (npc == 2'b10);
    dw  = ma & ~dr;
    for (int k = 0; k < 2; k++) begin
      get_obs(k, o, st, ps, pf);
      e_st = m_frz[k] ? 3 : (m_rd[k] > 0) ? 2 : (m_lu[k] > 0) ? 1 : 0;
      {e_pc, e_ifs, e_iff, e_ids, e_idb, e_exs} = 6'b0;
      if (dw) begin
        e_pc = 1; e_ifs = 1; e_ids = 1; e_exs = 1;
      end else if (exr) begin
        e_iff = 1; e_idb = 1;
        m_rd[k] = RC - 1; m_lu[k] = 0;
      end else if (idr) begin
        e_iff = 1;
        if (m_rd[k] > 0) m_rd[k]--;
        m_lu[k] = 0;
      end else if (m_rd[k] > 0) begin
        e_iff = 1; e_pc = !imr;
        m_rd[k]--;
      end else if (m_lu[k] > 0 || lu) begin
        e_pc = 1; e_ifs = 1; e_idb = 1;
        if (m_lu[k] > 0) m_lu[k]--;
        else m_lu[k] = luc[k] - 1;
      end else if (!imr) begin
        e_pc = 1; e_iff = 1;
      end
      m_frz[k] = dw;
      chk($sformatf("%s/%0d.pc_stall", tag, k),     32'(o[5]), 32'(e_pc));
      chk($sformatf("%s/%0d.if_id_stall", tag, k),  32'(o[4]), 32'(e_ifs));
      chk($sformatf("%s/%0d.if_id_flush", tag, k),  32'(o[3]), 32'(e_iff));
      chk($sformatf("%s/%0d.id_ex_stall", tag, k),  32'(o[2]), 32'(e_ids));
      chk($sformatf("%s/%0d.id_ex_bubble", tag, k), 32'(o[1]), 32'(e_idb));
      chk($sformatf("%s/%0d.ex_mem_stall", tag, k), 32'(o[0]), 32'(e_exs));
      chk($sformatf("%s/%0d.ctrl_state", tag, k),   32'(st),   32'(e_st));
      check_perf(tag, k, ps, pf);
      m_ps[k] = m_ps[k] + 32'(e_pc);
      m_pf[k] = m_pf[k] + 32'(e_iff);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check_in_reset(input string tag);
    logic [5:0] o; logic [2:0] st; logic [31:0] ps, pf;
    for (int k = 0; k < 2; k++) begin
      m_lu[k] = 0; m_rd[k] = 0; m_frz[k] = 0; m_ps[k] = '0; m_pf[k] = '0;
      get_obs(k, o, st, ps, pf);
      chk($sformatf("%s/%0d.outs", tag, k), 32'(o), 32'(6'b001010));
      chk($sformatf("%s/%0d.ctrl_state", tag, k), 32'(st), 32'd0);
      check_perf(tag, k, ps, pf);
    end
  endtask

  initial begin
    idle();
    drive();
    reset = 1'b0;
    #3;
    check_in_reset("por");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    // load x5 in EX, ID add x6,x5,x1
    idle(); mr = 1; rd = 5'd5; rs1 = 5'd5; rs2 = 5'd1; u1 = 1; u2 = 1;
    step("lu_hit");
    idle(); repeat (4) step("lu_after");
    // load to x0: no dependency
    mr = 1; rd = 5'd0; rs1 = 5'd0; u1 = 1;
    step("lu_x0");
    // rs2-only match
    idle(); mr = 1; rd = 5'd7; rs2 = 5'd7; u2 = 1; rs1 = 5'd7; u1 = 0;
    step("lu_rs2");
    idle(); repeat (3) step("lu_rs2_after");

    // taken branch in EX
    br = 1; step("branch");
    idle(); repeat (2) step("branch_after");

    // JAL resolved in ID
    npc = 2'b10; step("jal");
    idle(); repeat (2) step("jal_after");

    // data-memory wait during the redirect shadow
    br = 1; step("br_then_dw");
    idle(); ma = 1; dr = 0;
    repeat (3) step("dwait");
    idle(); repeat (3) step("dw_resume");

    // load-use and JALR together
    mr = 1; rd = 5'd3; rs1 = 5'd3; u1 = 1; jr = 1;
    step("lu_jalr");
    idle(); repeat (2) step("lu_jalr_after");

    // instruction memory waits, then with a JAL on top
    imr = 0; repeat (2) step("imem_wait");
    npc = 2'b10; step("imem_jal");
    idle(); step("imem_done");

    // wait on dmem while the 3-cycle load-use is in progress
    mr = 1; rd = 5'd9; rs1 = 5'd9; u1 = 1;
    step("lu3");
    idle(); step("lu3_mid");
    ma = 1; dr = 0; repeat (2) step("lu3_dw");
    idle(); repeat (3) step("lu3_resume");

    // reset mid-LOAD_USE on the 3-cycle instance
    mr = 1; rd = 5'd4; rs2 = 5'd4; u2 = 1;
    step("lu_pre_rst");
    idle(); drive();
    reset = 1'b0;
    #1;
    check_in_reset("rst_mid_lu");
    @(posedge clock);
    #1;
    check_in_reset("rst_held");
    reset = 1'b1;
    repeat (2) step("post_rst");

    // constrained-random traffic
    for (int i = 0; i < 1500; i++) begin
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      u1  = 1'($urandom_range(0, 1));
      u2  = 1'($urandom_range(0, 1));
      mr  = 1'($urandom_range(0, 1));
      npc = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'($urandom_range(0, 1) * 3);
      br  = ($urandom_range(0, 9) == 0);
      jr  = ($urandom_range(0, 15) == 0);
      imr = ($urandom_range(0, 3) != 0);
      ma  = 1'($urandom_range(0, 1));
      dr  = ($urandom_range(0, 2) != 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
